// File: rtl/argmax_pkg.sv
// argmax_pkg: state encoding, width helper and default sizes
// shared by the argmax engine and the product-matrix memory.
package argmax_pkg;

    localparam int ARGMAX_NUM_ROWS    = 6;
    localparam int ARGMAX_NUM_CLASSES = 3;
    localparam int ARGMAX_DATA_WIDTH  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_SCAN,
        ST_WRITE,
        ST_DONE
    } argmax_state_e;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/argmax_lane_cmp.sv
// argmax_lane_cmp: folds one beat of LANES scores into the running
// best {idx, max}; strict greater-than keeps the lowest index on ties.
module argmax_lane_cmp #(
    parameter int LANES      = 1,
    parameter int DATA_WIDTH = 16,
    parameter int IDX_W      = 2
) (
    input  logic [LANES*DATA_WIDTH-1:0] lanes_i,
    input  logic [LANES-1:0]            valid_i,
    input  logic [IDX_W-1:0]            base_i,
    input  logic                        signed_i,
    input  logic [IDX_W-1:0]            idx_i,
    input  logic [DATA_WIDTH-1:0]       max_i,
    output logic [IDX_W-1:0]            idx_o,
    output logic [DATA_WIDTH-1:0]       max_o
);

    logic [DATA_WIDTH-1:0] score;
    logic                  gt;

    // Lanes are folded in ascending order so a tie never displaces
    // an earlier lane or an earlier beat.
    always_comb begin
        idx_o = idx_i;
        max_o = max_i;
        score = '0;
        gt    = 1'b0;
        for (int j = 0; j < LANES; j++) begin
            score = lanes_i[j*DATA_WIDTH +: DATA_WIDTH];
            gt    = signed_i ? ($signed(score) > $signed(max_o))
                             : (score > max_o);
            if (valid_i[j] && gt) begin
                idx_o = base_i + IDX_W'(j);
                max_o = score;
            end
        end
    end

endmodule

// File: rtl/argmax_engine.sv
// argmax_engine: per-row argmax over the FM x WM x ADJ product with
// latency-tolerant row fetch, lane-limited scan and result readout.
module argmax_engine
    import argmax_pkg::*;
#(
    parameter int  NUM_ROWS    = ARGMAX_NUM_ROWS,
    parameter int  NUM_CLASSES = ARGMAX_NUM_CLASSES,
    parameter int  DATA_WIDTH  = ARGMAX_DATA_WIDTH,
    parameter int  LANES       = 1,
    parameter int  RD_LATENCY  = 1,
    localparam int ROW_W       = clog2_min1(NUM_ROWS),
    localparam int IDX_W       = clog2_min1(NUM_CLASSES)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              signed_mode,
    output logic [ROW_W-1:0]                  read_row,
    output logic                              read_en,
    input  logic [NUM_CLASSES*DATA_WIDTH-1:0] row_data,
    output logic                              busy,
    output logic                              done,
    input  logic [ROW_W-1:0]                  res_addr,
    output logic [IDX_W-1:0]                  res_idx,
    output logic [DATA_WIDTH-1:0]             res_max,
    output logic [NUM_ROWS*IDX_W-1:0]         max_idx_all
);

    localparam int BEATS  = (NUM_CLASSES + LANES - 1) / LANES;
    localparam int BEAT_W = clog2_min1(BEATS);
    localparam int WAIT_W = clog2_min1(RD_LATENCY);
    localparam int PAD_W  = BEATS * LANES * DATA_WIDTH;

    argmax_state_e state_q;

    logic [ROW_W-1:0]                  row_q;
    logic [ROW_W-1:0]                  read_row_q;
    logic [WAIT_W-1:0]                 wait_q;
    logic [BEAT_W-1:0]                 beat_q;
    logic                              signed_q;
    logic                              read_en_q;
    logic                              busy_q;
    logic                              done_q;
    logic [NUM_CLASSES*DATA_WIDTH-1:0] buf_q;
    logic [IDX_W-1:0]                  best_idx_q;
    logic [IDX_W-1:0]                  best_idx_d;
    logic [DATA_WIDTH-1:0]             best_max_q;
    logic [DATA_WIDTH-1:0]             best_max_d;

    logic [IDX_W-1:0]      idx_mem_q [NUM_ROWS];
    logic [DATA_WIDTH-1:0] max_mem_q [NUM_ROWS];

    logic [PAD_W-1:0]            buf_pad;
    logic [LANES*DATA_WIDTH-1:0] beat_lanes;
    logic [LANES-1:0]            beat_valid;
    logic [IDX_W-1:0]            beat_base;

    logic last_wait;
    logic last_beat;
    logic last_row;

    assign last_wait = (wait_q == WAIT_W'(RD_LATENCY - 1));
    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
    assign last_row  = (row_q == ROW_W'(NUM_ROWS - 1));

    // The row buffer is zero-padded to whole beats; the padding lanes
    // are masked so they can never win, even against negative scores.
    always_comb begin
        buf_pad = '0;
        buf_pad[NUM_CLASSES*DATA_WIDTH-1:0] = buf_q;
        beat_lanes = buf_pad[int'(beat_q)*LANES*DATA_WIDTH +: LANES*DATA_WIDTH];
        beat_base  = IDX_W'(int'(beat_q) * LANES);
        beat_valid = '0;
        for (int j = 0; j < LANES; j++) begin
            beat_valid[j] = (int'(beat_q) * LANES + j) < NUM_CLASSES;
        end
    end

    argmax_lane_cmp #(
        .LANES      (LANES),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_cmp (
        .lanes_i  (beat_lanes),
        .valid_i  (beat_valid),
        .base_i   (beat_base),
        .signed_i (signed_q),
        .idx_i    (best_idx_q),
        .max_i    (best_max_q),
        .idx_o    (best_idx_d),
        .max_o    (best_max_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            read_row_q <= '0;
            wait_q     <= '0;
            beat_q     <= '0;
            signed_q   <= 1'b0;
            read_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            buf_q      <= '0;
            best_idx_q <= '0;
            best_max_q <= '0;
        end else begin
            read_en_q <= 1'b0;
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q    <= ST_FETCH;
                        signed_q   <= signed_mode;
                        read_en_q  <= 1'b1;
                        read_row_q <= row_q;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    state_q <= ST_WAIT;
                    wait_q  <= '0;
                end
                ST_WAIT: begin
                    wait_q <= wait_q + 1'b1;
                    if (last_wait) begin
                        state_q    <= ST_SCAN;
                        buf_q      <= row_data;
                        beat_q     <= '0;
                        best_idx_q <= '0;
                        best_max_q <= row_data[DATA_WIDTH-1:0];
                    end
                end
                ST_SCAN: begin
                    best_idx_q <= best_idx_d;
                    best_max_q <= best_max_d;
                    beat_q     <= beat_q + 1'b1;
                    if (last_beat) begin
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (last_row) begin
                        state_q <= ST_DONE;
                        row_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= ST_FETCH;
                        row_q      <= row_q + 1'b1;
                        read_row_q <= row_q + 1'b1;
                        read_en_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                idx_mem_q[r] <= '0;
                max_mem_q[r] <= '0;
            end
        end else if (state_q == ST_WRITE) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (row_q == ROW_W'(r)) begin
                    idx_mem_q[r] <= best_idx_q;
                    max_mem_q[r] <= best_max_q;
                end
            end
        end
    end

    always_comb begin
        res_idx     = '0;
        res_max     = '0;
        max_idx_all = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            max_idx_all[r*IDX_W +: IDX_W] = idx_mem_q[r];
            if (res_addr == ROW_W'(r)) begin
                res_idx = idx_mem_q[r];
                res_max = max_mem_q[r];
            end
        end
    end

    assign read_row = read_row_q;
    assign read_en  = read_en_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_argmax_engine.sv
// tb_argmax_engine: randomized checks of argmax_engine against a
// plain-arithmetic argmax model, two parameter sets.
`timescale 1ns/1ps
module tb_argmax_engine;

    localparam int DW   = 16;
    localparam int R1   = 6;
    localparam int C1   = 3;
    localparam int LAT1 = 1;
    localparam int RW1  = 3;
    localparam int IW1  = 2;
    localparam int P1   = 2 + LAT1 + C1;
    localparam int R2   = 3;
    localparam int C2   = 7;
    localparam int LN2  = 3;
    localparam int LAT2 = 3;
    localparam int RW2  = 2;
    localparam int IW2  = 3;
    localparam int P2   = 2 + LAT2 + (C2 + LN2 - 1) / LN2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int errors = 0;

    logic             start1, sm1, read_en1, busy1, done1;
    logic [RW1-1:0]   read_row1, res_addr1;
    logic [C1*DW-1:0] row_data1, junk1;
    logic [IW1-1:0]   res_idx1;
    logic [DW-1:0]    res_max1;
    logic [R1*IW1-1:0] all1;

    logic             start2, sm2, read_en2, busy2, done2;
    logic [RW2-1:0]   read_row2, res_addr2;
    logic [C2*DW-1:0] row_data2, junk2;
    logic [IW2-1:0]   res_idx2;
    logic [DW-1:0]    res_max2;
    logic [R2*IW2-1:0] all2;

    logic [DW-1:0] mem1 [R1][C1];
    logic [DW-1:0] mem2 [R2][C2];
    int            exp_idx1 [R1];
    int            old_idx1 [R1];
    logic [DW-1:0] exp_max1 [R1];
    int            exp_idx2 [R2];
    logic [DW-1:0] exp_max2 [R2];

    logic [RW1-1:0] pa1 [LAT1];
    logic           pv1 [LAT1];
    logic [RW2-1:0] pa2 [LAT2];
    logic           pv2 [LAT2];

    argmax_engine #(
        .NUM_ROWS(R1), .NUM_CLASSES(C1), .DATA_WIDTH(DW),
        .LANES(1), .RD_LATENCY(LAT1)
    ) dut1 (
        .clk(clk), .reset(reset), .start(start1), .signed_mode(sm1),
        .read_row(read_row1), .read_en(read_en1), .row_data(row_data1),
        .busy(busy1), .done(done1), .res_addr(res_addr1),
        .res_idx(res_idx1), .res_max(res_max1), .max_idx_all(all1)
    );

    argmax_engine #(
        .NUM_ROWS(R2), .NUM_CLASSES(C2), .DATA_WIDTH(DW),
        .LANES(LN2), .RD_LATENCY(LAT2)
    ) dut2 (
        .clk(clk), .reset(reset), .start(start2), .signed_mode(sm2),
        .read_row(read_row2), .read_en(read_en2), .row_data(row_data2),
        .busy(busy2), .done(done2), .res_addr(res_addr2),
        .res_idx(res_idx2), .res_max(res_max2), .max_idx_all(all2)
    );

    // product-matrix memories with RD_LATENCY read pipelines; random
    // junk is presented whenever no read result is due
    always @(posedge clk) begin
        pv1[0] <= read_en1;
        pa1[0] <= read_row1;
        for (int i = 1; i < LAT1; i++) begin
            pv1[i] <= pv1[i-1];
            pa1[i] <= pa1[i-1];
        end
        pv2[0] <= read_en2;
        pa2[0] <= read_row2;
        for (int i = 1; i < LAT2; i++) begin
            pv2[i] <= pv2[i-1];
            pa2[i] <= pa2[i-1];
        end
        for (int c = 0; c < C1; c++) junk1[c*DW +: DW] <= DW'($urandom);
        for (int c = 0; c < C2; c++) junk2[c*DW +: DW] <= DW'($urandom);
    end

    always_comb begin
        row_data1 = junk1;
        row_data2 = junk2;
        if (pv1[LAT1-1] === 1'b1)
            for (int c = 0; c < C1; c++)
                row_data1[c*DW +: DW] = mem1[pa1[LAT1-1]][c];
        if (pv2[LAT2-1] === 1'b1)
            for (int c = 0; c < C2; c++)
                row_data2[c*DW +: DW] = mem2[pa2[LAT2-1]][c];
    end

    // reference: first index holding the largest score
    function automatic int ref_idx(input logic [DW-1:0] s[$], input bit sm);
        int b = 0;
        for (int i = 1; i < s.size(); i++) begin
            if (sm ? ($signed(s[i]) > $signed(s[b])) : (s[i] > s[b])) b = i;
        end
        return b;
    endfunction

    function automatic logic [DW-1:0] rnd_score();
        case ($urandom_range(0, 3))
            0: return DW'($urandom);
            1: return DW'($urandom_range(0, 3));
            2: return 16'hFFFF - DW'($urandom_range(0, 2));
            default: return 16'h8000 + DW'($urandom_range(0, 2));
        endcase
    endfunction

    task automatic fill_random1();
        for (int r = 0; r < R1; r++)
            for (int c = 0; c < C1; c++) mem1[r][c] = rnd_score();
    endtask

    task automatic run_pass1(input bit sm, input bit poke, input string tag);
        int k, lat, nf;
        bit seen;
        logic [DW-1:0] q[$];
        old_idx1 = exp_idx1;
        for (int r = 0; r < R1; r++) begin
            q.delete();
            for (int c = 0; c < C1; c++) q.push_back(mem1[r][c]);
            exp_idx1[r] = ref_idx(q, sm);
            exp_max1[r] = mem1[r][exp_idx1[r]];
        end
        @(negedge clk);
        sm1 = sm;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        k = edge_cnt;
        start1 = 1'b0;
        checks++;
        if (busy1 !== 1'b1 || read_en1 !== 1'b1 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: busy=%b read_en=%b done=%b, want 1 1 0",
                     tag, busy1, read_en1, done1);
        end
        nf = 0;
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (poke && i == 9) begin
                start1 = 1'b1;
                sm1 = ~sm;
            end
            if (poke && i == 10) start1 = 1'b0;
            if (read_en1 === 1'b1) begin
                checks++;
                if (nf >= R1 || read_row1 !== RW1'(nf)
                    || all1[nf*IW1 +: IW1] !== IW1'(old_idx1[nf])
                    || (nf > 0 && all1[(nf-1)*IW1 +: IW1] !== IW1'(exp_idx1[nf-1]))) begin
                    errors++;
                    $display("FAIL %s fetch%0d: row=%0d all=%h, want row=%0d prev=%0d old=%0d",
                             tag, nf, read_row1, all1, nf,
                             (nf > 0) ? exp_idx1[nf-1] : 0, old_idx1[nf]);
                end
                nf++;
            end
            if (done1 === 1'b1) seen = 1;
        end
        lat = seen ? edge_cnt - k : -1;
        checks++;
        if (lat != R1 * P1 || nf != R1 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL %s timing: done after %0d edges, %0d fetches, busy=%b; want %0d, %0d, 0",
                     tag, lat, nf, busy1, R1 * P1, R1);
        end
        for (int r = 0; r < R1; r++) begin
            res_addr1 = RW1'(r);
            #1;
            checks++;
            if (res_idx1 !== IW1'(exp_idx1[r]) || res_max1 !== exp_max1[r]
                || all1[r*IW1 +: IW1] !== IW1'(exp_idx1[r])) begin
                errors++;
                $display("FAIL %s row%0d: idx=%0d max=%h all=%0d, want idx=%0d max=%h",
                         tag, r, res_idx1, res_max1, all1[r*IW1 +: IW1],
                         exp_idx1[r], exp_max1[r]);
            end
        end
        sm1 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (done1 !== 0 || busy1 !== 0 || read_en1 !== 0 || read_row1 !== 0
            || all1 !== '0 || done2 !== 0 || busy2 !== 0 || all2 !== '0) begin
            errors++;
            $display("FAIL reset outputs: done=%b busy=%b ren=%b row=%0d all=%h, want zeros",
                     done1, busy1, read_en1, read_row1, all1);
        end
        for (int r = 0; r < R1; r++) begin
            res_addr1 = RW1'(r);
            #1;
            checks++;
            if (res_idx1 !== '0 || res_max1 !== '0) begin
                errors++;
                $display("FAIL reset row%0d: idx=%0d max=%h, want 0 0", r, res_idx1, res_max1);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        exp_idx1 = '{default: 0};
        exp_max1 = '{default: '0};
    endtask

    task automatic test_unsigned_plan();
        logic [R1*IW1-1:0] want;
        mem1[0] = '{16'h3, 16'h9, 16'h2};
        mem1[1] = '{16'h7, 16'h7, 16'h1};
        mem1[2] = '{16'h0, 16'h0, 16'h0};
        mem1[3] = '{16'h1, 16'h2, 16'h5};
        mem1[4] = '{16'hFFFF, 16'h0, 16'h1};
        mem1[5] = '{16'h4, 16'h4, 16'h4};
        run_pass1(1'b0, 1'b0, "plan");
        want = 12'b00_00_10_00_00_01;
        res_addr1 = 3'd4;
        #1;
        checks++;
        if (all1 !== want || res_max1 !== 16'hFFFF) begin
            errors++;
            $display("FAIL plan_const: all=%h max4=%h, want %h FFFF", all1, res_max1, want);
        end
    endtask

    task automatic test_signed();
        fill_random1();
        mem1[0] = '{16'hFFFF, 16'hFFFE, 16'h8000};
        mem1[1] = '{16'h8000, 16'h0001, 16'h7FFF};
        run_pass1(1'b1, 1'b0, "signed");
        run_pass1(1'b0, 1'b0, "unsigned");
        fill_random1();
        run_pass1(1'b1, 1'b0, "signed_rand");
    endtask

    task automatic test_start_while_busy();
        fill_random1();
        run_pass1(1'b1, 1'b1, "busy_start_s");
        fill_random1();
        run_pass1(1'b0, 1'b1, "busy_start_u");
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        fill_random1();
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clk);
            if (read_en1 === 1'b1 && read_row1 === 3'd2) hit = 1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reset_mid: no fetch of row 2 seen, want one");
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (done1 !== 0 || busy1 !== 0 || read_en1 !== 0 || read_row1 !== 0 || all1 !== '0) begin
            errors++;
            $display("FAIL reset_mid outputs: done=%b busy=%b ren=%b row=%0d all=%h, want zeros",
                     done1, busy1, read_en1, read_row1, all1);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy1 !== 0 || read_en1 !== 0) begin
            errors++;
            $display("FAIL reset_mid idle: busy=%b ren=%b, want 0 0", busy1, read_en1);
        end
        exp_idx1 = '{default: 0};
        exp_max1 = '{default: '0};
        run_pass1(1'b1, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        fill_random1();
        run_pass1(1'b0, 1'b0, "b2b_a");
        fill_random1();
        run_pass1(1'b1, 1'b0, "b2b_b");
    endtask

    task automatic run_pass2(input bit sm, input string tag);
        int k, nf, lastf;
        bit seen;
        logic [DW-1:0] q[$];
        for (int r = 0; r < R2; r++) begin
            q.delete();
            for (int c = 0; c < C2; c++) q.push_back(mem2[r][c]);
            exp_idx2[r] = ref_idx(q, sm);
            exp_max2[r] = mem2[r][exp_idx2[r]];
        end
        @(negedge clk);
        sm2 = sm;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        k = edge_cnt;
        start2 = 1'b0;
        nf = 0;
        lastf = -1;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (read_en2 === 1'b1) begin
                checks++;
                if (nf >= R2 || read_row2 !== RW2'(nf) || (lastf >= 0 && edge_cnt - lastf != P2)) begin
                    errors++;
                    $display("FAIL %s fetch%0d: row=%0d gap=%0d, want row=%0d gap=%0d",
                             tag, nf, read_row2, edge_cnt - lastf, nf, P2);
                end
                lastf = edge_cnt;
                nf++;
            end
            if (done2 === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || edge_cnt - k != R2 * P2 || nf != R2) begin
            errors++;
            $display("FAIL %s timing: seen=%0d edges=%0d fetches=%0d, want 1 %0d %0d",
                     tag, seen, edge_cnt - k, nf, R2 * P2, R2);
        end
        for (int r = 0; r < R2; r++) begin
            res_addr2 = RW2'(r);
            #1;
            checks++;
            if (res_idx2 !== IW2'(exp_idx2[r]) || res_max2 !== exp_max2[r]
                || all2[r*IW2 +: IW2] !== IW2'(exp_idx2[r])) begin
                errors++;
                $display("FAIL %s row%0d: idx=%0d max=%h, want idx=%0d max=%h",
                         tag, r, res_idx2, res_max2, exp_idx2[r], exp_max2[r]);
            end
        end
    endtask

    task automatic test_lanes();
        mem2[0] = '{16'h1, 16'h1, 16'h1, 16'h1, 16'h1, 16'h1, 16'h9};
        for (int c = 0; c < C2; c++) mem2[1][c] = 16'h8000 + DW'($urandom_range(0, 255));
        for (int c = 0; c < C2; c++) mem2[2][c] = rnd_score();
        run_pass2(1'b1, "lanes_s");
        run_pass2(1'b0, "lanes_u");
        for (int r = 0; r < R2; r++)
            for (int c = 0; c < C2; c++) mem2[r][c] = rnd_score();
        mem2[0] = '{16'h5, 16'h5, 16'h5, 16'h5, 16'h5, 16'h5, 16'h5};
        run_pass2(1'b1, "lanes_rand");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        start1 = 1'b0;
        sm1 = 1'b0;
        res_addr1 = '0;
        start2 = 1'b0;
        sm2 = 1'b0;
        res_addr2 = '0;
        test_reset();
        test_unsigned_plan();
        test_signed();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        test_lanes();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
